// File: rtl/button_debounce_pulse.sv
// Push-button front end: two-flop synchroniser, counter-driven debounce FSM,
// one-cycle press pulse, debounced level, one-shot long-press pulse and press counter.
module button_debounce_pulse #(
   parameter int unsigned DEBOUNCE_CNT = 1000000,
   parameter int unsigned LONG_CNT     = 100000000,
   parameter int unsigned CNT_W        = 32
) (
   input  logic       clk_g,
   input  logic       rst_n,
   input  logic       btn_in,
   output logic       btn_pulse,
   output logic       btn_level,
   output logic       btn_long,
   output logic [7:0] press_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_CHK,
      PRESSED,
      RELEASE_CHK
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CNT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state;
   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] deb_cnt;
   logic [CNT_W-1:0] hold_cnt;

   // NOTE: every register here is assigned with <= so all flops sample the
   // pre-edge values; blocking assignments would let s1 fall straight into s2.
   always_ff @(posedge clk_g) begin
      // NOTE: reset is tested inside the clocked block, so it only acts on an edge
      // and wins over every state, including mid-debounce and mid-hold.
      if (!rst_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         state     <= IDLE;
         deb_cnt   <= '0;
         hold_cnt  <= '0;
         btn_pulse <= 1'b0;
         btn_level <= 1'b0;
         btn_long  <= 1'b0;
         press_cnt <= 8'd0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;

         // Pulses default low so they last exactly one cycle.
         btn_pulse <= 1'b0;
         btn_long  <= 1'b0;

         case (state)
            IDLE: begin
               if (s2) begin
                  state   <= PRESS_CHK;
                  deb_cnt <= '0;
               end
            end

            PRESS_CHK: begin
               if (!s2) begin
                  state <= IDLE;
               end else if (deb_cnt == DEB_LAST) begin
                  state     <= PRESSED;
                  btn_pulse <= 1'b1;
                  btn_level <= 1'b1;
                  hold_cnt  <= '0;
                  press_cnt <= press_cnt + 8'd1;
               end else begin
                  deb_cnt <= deb_cnt + CNT_ONE;
               end
            end

            PRESSED: begin
               if (!s2) begin
                  state   <= RELEASE_CHK;
                  deb_cnt <= '0;
               end else if (hold_cnt < LONG_LAST) begin
                  hold_cnt <= hold_cnt + CNT_ONE;
               end else if (hold_cnt == LONG_LAST) begin
                  // Saturating past LONG_LAST keeps btn_long to one shot per press.
                  btn_long <= 1'b1;
                  hold_cnt <= LONG_SAT;
               end
            end

            RELEASE_CHK: begin
               if (s2) begin
                  state <= PRESSED;
               end else if (deb_cnt == DEB_LAST) begin
                  state     <= IDLE;
                  btn_level <= 1'b0;
               end else begin
                  deb_cnt <= deb_cnt + CNT_ONE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse with DEBOUNCE_CNT=4, LONG_CNT=20.
module tb_button_debounce_pulse;

   localparam int unsigned DEB  = 4;
   localparam int unsigned LONG = 20;

   logic       clk_g = 1'b0;
   logic       rst_n;
   logic       btn_in;
   logic       btn_pulse;
   logic       btn_level;
   logic       btn_long;
   logic [7:0] press_cnt;

   int total = 0;
   int bad   = 0;
   int n_pulse = 0;
   int n_long  = 0;
   int n_both  = 0;

   button_debounce_pulse #(
      .DEBOUNCE_CNT(DEB),
      .LONG_CNT    (LONG),
      .CNT_W       (32)
   ) dut (
      .clk_g    (clk_g),
      .rst_n    (rst_n),
      .btn_in   (btn_in),
      .btn_pulse(btn_pulse),
      .btn_level(btn_level),
      .btn_long (btn_long),
      .press_cnt(press_cnt)
   );

   always #5 clk_g = ~clk_g;

   // Event counters sampled mid-cycle, away from the active edge.
   always @(negedge clk_g) begin
      if (btn_pulse === 1'b1) n_pulse <= n_pulse + 1;
      if (btn_long === 1'b1) n_long <= n_long + 1;
      if (btn_pulse === 1'b1 && btn_long === 1'b1) n_both <= n_both + 1;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_g);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press_release();
      btn_in = 1'b1;
      tick(8);
      btn_in = 1'b0;
      tick(8);
   endtask

   initial begin
      // Reset held with the pad high: everything stays cleared.
      rst_n  = 1'b0;
      btn_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_pulse", 32'(btn_pulse), 32'd0);
         chk("rst_level", 32'(btn_level), 32'd0);
         chk("rst_long", 32'(btn_long), 32'd0);
         chk("rst_cnt", 32'(press_cnt), 32'd0);
      end
      rst_n  = 1'b1;
      btn_in = 1'b0;
      tick(10);
      chk("post_rst_pulses", n_pulse, 0);
      chk("post_rst_level", 32'(btn_level), 32'd0);

      // Clean press: first high sample at edge k, pulse after edge k+6.
      btn_in = 1'b1;
      tick(6);
      chk("clean_early", 32'(btn_pulse), 32'd0);
      tick();
      chk("clean_pulse", 32'(btn_pulse), 32'd1);
      chk("clean_level", 32'(btn_level), 32'd1);
      chk("clean_cnt", 32'(press_cnt), 32'd1);
      tick();
      chk("clean_pulse_end", 32'(btn_pulse), 32'd0);
      chk("clean_level_hold", 32'(btn_level), 32'd1);

      // Release: first low sample at edge j, level drops after edge j+6.
      btn_in = 1'b0;
      tick(6);
      chk("rel_level_early", 32'(btn_level), 32'd1);
      tick();
      chk("rel_level", 32'(btn_level), 32'd0);
      chk("clean_npulse", n_pulse, 1);
      chk("clean_nlong", n_long, 0);

      // Press bounce: 1,0,1,0 with 2-cycle widths, then stable high.
      for (int i = 0; i < 4; i++) begin
         btn_in = (i % 2 == 0) ? 1'b1 : 1'b0;
         tick(2);
      end
      btn_in = 1'b1;
      tick(6);
      chk("bounce_early", 32'(btn_pulse), 32'd0);
      chk("bounce_npulse", n_pulse, 1);
      tick();
      chk("bounce_pulse", 32'(btn_pulse), 32'd1);
      chk("bounce_cnt", 32'(press_cnt), 32'd2);

      // Long press: btn_long exactly 20 edges after the pulse edge.
      tick(19);
      chk("long_early", 32'(btn_long), 32'd0);
      tick();
      chk("long_fire", 32'(btn_long), 32'd1);
      chk("long_no_pulse", 32'(btn_pulse), 32'd0);
      tick();
      chk("long_end", 32'(btn_long), 32'd0);
      tick(30);
      chk("long_once", n_long, 1);
      chk("long_npulse", n_pulse, 2);

      // Release glitch while pressed: two low cycles, back high.
      btn_in = 1'b0;
      tick(2);
      btn_in = 1'b1;
      tick(10);
      chk("glitch_level", 32'(btn_level), 32'd1);
      chk("glitch_cnt", 32'(press_cnt), 32'd2);
      chk("glitch_npulse", n_pulse, 2);
      chk("glitch_nlong", n_long, 1);

      // Full release after the glitch.
      btn_in = 1'b0;
      tick(6);
      chk("full_rel_early", 32'(btn_level), 32'd1);
      tick();
      chk("full_rel_level", 32'(btn_level), 32'd0);

      // Counter wrap: 2 + 253 = 255, one more wraps to 0.
      repeat (253) press_release();
      chk("wrap_255", 32'(press_cnt), 32'd255);
      press_release();
      chk("wrap_0", 32'(press_cnt), 32'd0);
      chk("wrap_npulse", n_pulse, 256);

      // Reset in PRESS_CHK with deb_cnt=2 (after edge k+4).
      btn_in = 1'b1;
      tick(5);
      chk("mid_pre_pulse", 32'(btn_pulse), 32'd0);
      rst_n  = 1'b0;
      btn_in = 1'b0;
      tick();
      chk("mid_rst_pulse", 32'(btn_pulse), 32'd0);
      chk("mid_rst_level", 32'(btn_level), 32'd0);
      chk("mid_rst_cnt", 32'(press_cnt), 32'd0);
      rst_n = 1'b1;
      tick(20);
      chk("mid_no_pulse", n_pulse, 256);
      chk("mid_level", 32'(btn_level), 32'd0);

      // Fresh press after reset sees a full debounce window.
      btn_in = 1'b1;
      tick(6);
      chk("fresh_early", 32'(btn_pulse), 32'd0);
      tick();
      chk("fresh_pulse", 32'(btn_pulse), 32'd1);
      chk("fresh_cnt", 32'(press_cnt), 32'd1);
      tick();
      btn_in = 1'b0;
      tick(10);
      chk("no_overlap", n_both, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
